// File: rtl/loss_grad_if.sv
// Handshake and vector bus between the loss stage and the loss-gradient unit.
interface loss_grad_if #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int size  = 16,
    parameter int width = $clog2(size)
);
    localparam int W = IL + FL;

    logic                     model;
    logic [size-1:0][W-1:0]   yHat;
    logic [size-1:0][W-1:0]   y;
    logic [width-1:0]         num;
    logic [W-1:0]             inv_num;
    logic                     input_ready;
    logic                     output_taken;
    logic [1:0]               state;
    logic [size-1:0][W-1:0]   grad;

    modport master (
        output model, yHat, y, num, inv_num, input_ready, output_taken,
        input  state, grad
    );

    modport slave (
        input  model, yHat, y, num, inv_num, input_ready, output_taken,
        output state, grad
    );
endinterface

// File: rtl/loss_grad.sv
// Serial dL/dyHat for L1/L2 loss: one element per cycle through one shared
// signed multiplier, IDLE/BUSY/DONE handshake matching the forward loss block.
module loss_grad #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int size  = 16,
    parameter int width = $clog2(size)
) (
    input  logic       clk,
    input  logic       reset,
    loss_grad_if.slave bus
);
    localparam int W  = IL + FL;
    localparam int PW = 2 * W + 2;
    localparam logic [width-1:0]     LAST   = width'(size - 1);
    localparam logic signed [PW-1:0] SAT_HI = {{(W + 3){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_LO = {{(W + 3){1'b1}}, {(W - 1){1'b0}}};
    // sgn(d) enters the multiplier as +/-1.0 so the common >>> FL rescale applies
    localparam logic signed [W+1:0]  ONE    = {{(IL + 1){1'b0}}, 1'b1, {FL{1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10} state_t;

    state_t                 cur, nxt;
    logic [size-1:0][W-1:0] yhat_q, y_q, grad_q;
    logic [width-1:0]       num_q, idx;
    logic [W-1:0]           inv_q;
    logic                   model_q;

    logic signed [W:0]      d;
    logic signed [W+1:0]    op_a;
    logic signed [PW-1:0]   prod, r;
    logic [W-1:0]           res;

    always_ff @(posedge clk) begin
        if (reset) cur <= IDLE;
        else       cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    if (bus.input_ready)  nxt = BUSY;
            BUSY:    if (idx == LAST)      nxt = DONE;
            DONE:    if (bus.output_taken) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        d = (W + 1)'($signed(yhat_q[idx])) - (W + 1)'($signed(y_q[idx]));
        if (model_q) begin
            if (d == '0)  op_a = '0;
            else if (d[W]) op_a = -ONE;
            else           op_a = ONE;
        end else begin
            op_a = $signed({d, 1'b0});
        end
        prod = PW'(op_a) * PW'($signed(inv_q));
        r    = prod >>> FL;
        if (r > SAT_HI)      res = SAT_HI[W-1:0];
        else if (r < SAT_LO) res = SAT_LO[W-1:0];
        else                 res = r[W-1:0];
        if (idx >= num_q) res = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            yhat_q  <= '0;
            y_q     <= '0;
            num_q   <= '0;
            inv_q   <= '0;
            model_q <= 1'b0;
            idx     <= '0;
            grad_q  <= '0;
        end else begin
            case (cur)
                IDLE: if (bus.input_ready) begin
                    yhat_q  <= bus.yHat;
                    y_q     <= bus.y;
                    num_q   <= bus.num;
                    inv_q   <= bus.inv_num;
                    model_q <= bus.model;
                    idx     <= '0;
                end
                BUSY: begin
                    grad_q[idx] <= res;
                    idx         <= (idx == LAST) ? '0 : idx + 1'b1;
                end
                DONE: if (bus.output_taken) begin
                    yhat_q  <= '0;
                    y_q     <= '0;
                    num_q   <= '0;
                    inv_q   <= '0;
                    model_q <= 1'b0;
                    idx     <= '0;
                    grad_q  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.state = cur;
    assign bus.grad  = grad_q;
endmodule

// File: tb/tb_loss_grad.sv
// Directed bench for loss_grad: L1/L2 values, masking, saturation, truncation,
// handshake corner cases and mid-run reset, with hand-computed expectations.
module tb_loss_grad;
    localparam int IL = 4, FL = 16, SZ = 16, WD = 4, W = IL + FL;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    loss_grad_if #(.IL(IL), .FL(FL), .size(SZ), .width(WD)) bus ();
    loss_grad #(.IL(IL), .FL(FL), .size(SZ), .width(WD)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0, failures = 0;
    logic signed [63:0] exp_g [SZ];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic signed [63:0] g(input int i);
        return 64'($signed(bus.grad[i]));
    endfunction

    function automatic logic [W-1:0] fx(input int v);
        return W'(v);
    endfunction

    task automatic check_grad(input string tag);
        for (int i = 0; i < SZ; i++) chk($sformatf("%s_g%0d", tag, i), g(i), exp_g[i]);
    endtask

    task automatic zero_exp();
        for (int i = 0; i < SZ; i++) exp_g[i] = 0;
    endtask

    task automatic clear_inputs();
        bus.model = 1'b0; bus.yHat = '0; bus.y = '0; bus.num = '0; bus.inv_num = '0;
    endtask

    task automatic set_basic(input logic [WD-1:0] n);
        clear_inputs();
        bus.num = n; bus.inv_num = fx(16384);
        for (int i = 0; i < SZ; i++) begin bus.yHat[i] = fx(65536); bus.y[i] = fx(32768); end
    endtask

    task automatic accept();
        bus.input_ready = 1'b1; tick(); bus.input_ready = 1'b0;
    endtask

    // Counts edges until DONE, bounded so a stuck FSM still reaches the summary.
    task automatic wait_done(input string tag, input int expv);
        int cnt = 0;
        while (bus.state !== 2'b10 && cnt < 40) begin tick(); cnt++; end
        chk(tag, 64'(cnt), 64'(expv));
    endtask

    task automatic ack();
        bus.output_taken = 1'b1; tick(); bus.output_taken = 1'b0;
    endtask

    initial begin
        bus.input_ready = 1'b0; bus.output_taken = 1'b0;
        clear_inputs();
        reset = 1'b1; tick(2); reset = 1'b0;
        chk("rst_state", 64'(bus.state), 0);
        zero_exp(); check_grad("rst");

        // L2 basic: 2*0.5*0.25 = 0.25
        set_basic(4); accept();
        chk("l2_busy", 64'(bus.state), 1);
        tick();
        chk("l2_first_g0", g(0), 16384);
        chk("l2_first_g1", g(1), 0);
        wait_done("l2_latency", 15);
        zero_exp(); for (int i = 0; i < 4; i++) exp_g[i] = 16384;
        check_grad("l2");
        ack();
        chk("ack_state", 64'(bus.state), 0);
        zero_exp(); check_grad("ack");

        // num=0: all zero, same latency
        set_basic(0); accept();
        wait_done("num0_latency", 16);
        check_grad("num0");
        ack();

        // L1 sign, with 10 DONE cycles held without ack
        clear_inputs();
        bus.model = 1'b1; bus.num = 2; bus.inv_num = fx(32768);
        bus.yHat[0] = fx(16384); bus.y[0] = fx(65536);
        bus.yHat[1] = fx(1000);  bus.y[1] = fx(1000);
        bus.yHat[2] = fx(65536); bus.y[2] = fx(0);
        accept();
        wait_done("l1_latency", 16);
        zero_exp(); exp_g[0] = -32768;
        check_grad("l1");
        for (int c = 0; c < 10; c++) begin
            tick();
            chk($sformatf("hold_state%0d", c), 64'(bus.state), 2);
            chk($sformatf("hold_g0_%0d", c), g(0), -32768);
        end

        // ack and request together: IDLE first, new run one cycle later
        clear_inputs();
        bus.num = 2; bus.inv_num = fx(65536);
        bus.yHat[0] = fx(491520);  bus.y[0] = fx(-491520);
        bus.yHat[1] = fx(-491520); bus.y[1] = fx(491520);
        bus.output_taken = 1'b1; bus.input_ready = 1'b1;
        tick();
        bus.output_taken = 1'b0;
        chk("both_state", 64'(bus.state), 0);
        chk("both_g0", g(0), 0);
        tick();
        chk("restart_state", 64'(bus.state), 1);
        // input_ready stays high through BUSY: must not restart
        wait_done("sat_latency", 16);
        bus.input_ready = 1'b0;
        zero_exp(); exp_g[0] = 524287; exp_g[1] = -524288;
        check_grad("sat");
        ack();

        // truncation toward -inf; inputs scrambled after acceptance
        clear_inputs();
        bus.num = 1; bus.inv_num = fx(16384); bus.yHat[0] = fx(0); bus.y[0] = fx(1);
        accept();
        bus.model = 1'b1; bus.num = 15; bus.inv_num = fx(65536);
        for (int i = 0; i < SZ; i++) begin bus.yHat[i] = fx(65536); bus.y[i] = fx(0); end
        wait_done("trunc_latency", 16);
        zero_exp(); exp_g[0] = -1;
        check_grad("trunc");
        ack();

        // reset during the 5th BUSY cycle
        set_basic(4); accept();
        tick(4);
        chk("pre_rst_g3", g(3), 16384);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("midrst_state", 64'(bus.state), 0);
        zero_exp(); check_grad("midrst");
        begin
            int seen = 0;
            for (int c = 0; c < 20; c++) begin tick(); if (bus.state === 2'b10) seen++; end
            chk("midrst_no_done", 64'(seen), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
